// File: rtl/alu_mc_n_bits_if.sv
// Handshake/data bundle between the processor datapath and the multi-cycle ALU.
// The master drives requests and consumes results; the slave is the ALU.
interface alu_mc_n_bits_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [3:0]   ALUControl;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] RESULT;
    logic [3:0]   flags;
    logic         div_by_zero;

    modport master (
        output in_valid, A, B, ALUControl, out_ready,
        input  in_ready, out_valid, RESULT, flags, div_by_zero
    );

    modport slave (
        input  in_valid, A, B, ALUControl, out_ready,
        output in_ready, out_valid, RESULT, flags, div_by_zero
    );
endinterface

// File: rtl/alu_mc_n_bits.sv
// Multi-cycle N-bit ALU: single-cycle logic/arith/shift ops plus an iterative
// restoring divider for unsigned DIV/MOD, with valid/ready on both sides.
module alu_mc_n_bits #(
    parameter int N = 32
) (
    input logic            clk,
    input logic            reset_n,
    alu_mc_n_bits_if.slave bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [N-1:0]  result_q;
    logic [3:0]    flags_q;
    logic          dbz_q;
    logic [N-1:0]  quo_q;     // dividend bits shifting out, quotient bits shifting in
    logic [N-1:0]  rem_q;     // partial remainder, always < divisor
    logic [N-1:0]  dvs_q;     // latched divisor
    logic          is_mod_q;
    logic [CW-1:0] cnt_q;

    logic          accept;
    logic          is_div_op;
    logic          b_zero;
    logic [N:0]    sum_w;
    logic [N:0]    diff_w;
    logic [N-1:0]  alu_res;
    logic          alu_c;
    logic          alu_v;
    logic [N:0]    sr_w;
    logic [N:0]    trial_w;
    logic          step_ge;
    logic [N-1:0]  rem_step;
    logic [N-1:0]  quo_step;
    logic [N-1:0]  div_res;

    function automatic logic [3:0] flags_of(input logic [N-1:0] r, input logic c, input logic v);
        return {r[N-1], (r == '0), c, v};
    endfunction

    // in_ready depends only on state and out_ready so the requester never sees a loop
    assign bus.in_ready    = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.RESULT      = result_q;
    assign bus.flags       = flags_q;
    assign bus.div_by_zero = dbz_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign is_div_op = (bus.ALUControl[3:1] == 3'b101);
    assign b_zero    = (bus.B == '0);

    assign sum_w  = {1'b0, bus.A} + {1'b0, bus.B};
    assign diff_w = {1'b0, bus.A} - {1'b0, bus.B};

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // Since the shifted remainder is < 2*divisor, bit N of the trial is a clean borrow.
    assign sr_w     = {rem_q, quo_q[N-1]};
    assign trial_w  = sr_w - {1'b0, dvs_q};
    assign step_ge  = ~trial_w[N];
    assign rem_step = step_ge ? trial_w[N-1:0] : sr_w[N-1:0];
    assign quo_step = {quo_q[N-2:0], step_ge};
    assign div_res  = is_mod_q ? rem_step : quo_step;

    // Single-cycle result and carry/overflow; DIV/MOD entries here cover only B=0
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.ALUControl)
            4'b0000: begin
                alu_res = sum_w[N-1:0];
                alu_c   = sum_w[N];
                alu_v   = (bus.A[N-1] == bus.B[N-1]) && (sum_w[N-1] != bus.A[N-1]);
            end
            4'b0001: begin
                alu_res = diff_w[N-1:0];
                alu_c   = ~diff_w[N];
                alu_v   = (bus.A[N-1] != bus.B[N-1]) && (diff_w[N-1] != bus.A[N-1]);
            end
            4'b0010: alu_res = bus.A & bus.B;
            4'b0011: alu_res = bus.A | bus.B;
            4'b0100: alu_res = bus.A ^ bus.B;
            4'b0101: alu_res = ~bus.A;
            // Shift amounts >= N saturate to zero / sign fill by operator semantics
            4'b0110, 4'b1000: alu_res = bus.A << bus.B;
            4'b0111: alu_res = $unsigned($signed(bus.A) >>> bus.B);
            4'b1001: alu_res = bus.A >> bus.B;
            4'b1010: alu_res = '1;
            4'b1011: alu_res = bus.A;
            default: alu_res = '0;
        endcase
    end

    // Control FSM with registered result, flags and divide-by-zero indication
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            dbz_q    <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            is_mod_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_DIV: begin
                    quo_q <= quo_step;
                    rem_q <= rem_step;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q  <= S_DONE;
                        result_q <= div_res;
                        flags_q  <= flags_of(div_res, 1'b0, 1'b0);
                        dbz_q    <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        if (is_div_op && !b_zero) begin
                            state_q  <= S_DIV;
                            quo_q    <= bus.A;
                            rem_q    <= '0;
                            dvs_q    <= bus.B;
                            is_mod_q <= bus.ALUControl[0];
                            cnt_q    <= '0;
                        end else begin
                            state_q  <= S_DONE;
                            result_q <= alu_res;
                            flags_q  <= flags_of(alu_res, alu_c, alu_v);
                            dbz_q    <= is_div_op;
                        end
                    end else if (state_q == S_DONE && bus.out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc_n_bits.sv
// Directed bench for alu_mc_n_bits: an N=4 instance driven from a vector table
// and an N=8 instance used for backpressure and reset-during-divide sequences.
module tb_alu_mc_n_bits;
    logic clk = 1'b0;
    logic rst4_n;
    logic rst8_n;

    int total = 0;
    int bad   = 0;

    alu_mc_n_bits_if #(.N(4)) bus4 ();
    alu_mc_n_bits_if #(.N(8)) bus8 ();

    alu_mc_n_bits #(.N(4)) u_dut4 (.clk(clk), .reset_n(rst4_n), .bus(bus4));
    alu_mc_n_bits #(.N(8)) u_dut8 (.clk(clk), .reset_n(rst8_n), .bus(bus8));

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [3:0] flg;
        logic       dbz;
        int         edges;   // clock edges from accept edge to out_valid
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a request, wait for the accepting edge, then count edges to out_valid
    task automatic issue4(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          output int edges);
        int guard = 0;
        bus4.ALUControl = op;
        bus4.A          = a;
        bus4.B          = b;
        bus4.in_valid   = 1'b1;
        while (!bus4.in_ready && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        bus4.A        = ~a;
        bus4.B        = ~b;
        edges = 0;
        while (!bus4.out_valid && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int edges);
        int guard = 0;
        bus8.ALUControl = op;
        bus8.A          = a;
        bus8.B          = b;
        bus8.in_valid   = 1'b1;
        while (!bus8.in_ready && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        bus8.A        = ~a;
        bus8.B        = ~b;
        edges = 0;
        while (!bus8.out_valid && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  edges;
        int  seen_valid;

        // name, op, a, b, result, flags{N,Z,C,V}, div_by_zero, edges
        vecs.push_back('{"ADD 4+2",      4'b0000, 4'b0100, 4'b0010, 4'b0110, 4'b0000, 1'b0, 0});
        vecs.push_back('{"SUB 4-2",      4'b0001, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 1'b0, 0});
        vecs.push_back('{"AND",          4'b0010, 4'b0100, 4'b0010, 4'b0000, 4'b0100, 1'b0, 0});
        vecs.push_back('{"ORR",          4'b0011, 4'b0100, 4'b0010, 4'b0110, 4'b0000, 1'b0, 0});
        vecs.push_back('{"XOR",          4'b0100, 4'b0100, 4'b0010, 4'b0110, 4'b0000, 1'b0, 0});
        vecs.push_back('{"NOT",          4'b0101, 4'b0100, 4'b0010, 4'b1011, 4'b1000, 1'b0, 0});
        vecs.push_back('{"ADD ovf",      4'b0000, 4'b0111, 4'b0001, 4'b1000, 4'b1001, 1'b0, 0});
        vecs.push_back('{"SUB borrow",   4'b0001, 4'b0010, 4'b0100, 4'b1110, 4'b1000, 1'b0, 0});
        vecs.push_back('{"ADD carry",    4'b0000, 4'b1111, 4'b0001, 4'b0000, 4'b0110, 1'b0, 0});
        vecs.push_back('{"RSA 2",        4'b0111, 4'b1100, 4'b0010, 4'b1111, 4'b1000, 1'b0, 0});
        vecs.push_back('{"RSL 2",        4'b1001, 4'b1100, 4'b0010, 4'b0011, 4'b0000, 1'b0, 0});
        vecs.push_back('{"LSL 2",        4'b1000, 4'b1100, 4'b0010, 4'b0000, 4'b0100, 1'b0, 0});
        vecs.push_back('{"RSA 5",        4'b0111, 4'b1100, 4'b0101, 4'b1111, 4'b1000, 1'b0, 0});
        vecs.push_back('{"RSL 5",        4'b1001, 4'b1100, 4'b0101, 4'b0000, 4'b0100, 1'b0, 0});
        vecs.push_back('{"LSA 5",        4'b0110, 4'b1100, 4'b0101, 4'b0000, 4'b0100, 1'b0, 0});
        vecs.push_back('{"LSL 0",        4'b1000, 4'b1100, 4'b0000, 4'b1100, 4'b1000, 1'b0, 0});
        vecs.push_back('{"LSA 1",        4'b0110, 4'b0011, 4'b0001, 4'b0110, 4'b0000, 1'b0, 0});
        vecs.push_back('{"RSA pos 4",    4'b0111, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 0});
        vecs.push_back('{"DIV 8/2",      4'b1010, 4'b1000, 4'b0010, 4'b0100, 4'b0000, 1'b0, 4});
        vecs.push_back('{"MOD 11%3",     4'b1011, 4'b1011, 4'b0011, 4'b0010, 4'b0000, 1'b0, 4});
        vecs.push_back('{"DIV 5/0",      4'b1010, 4'b0101, 4'b0000, 4'b1111, 4'b1000, 1'b1, 0});
        vecs.push_back('{"MOD 5%0",      4'b1011, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 1'b1, 0});
        vecs.push_back('{"DIV 15/1",     4'b1010, 4'b1111, 4'b0001, 4'b1111, 4'b1000, 1'b0, 4});
        vecs.push_back('{"MOD 7%9",      4'b1011, 4'b0111, 4'b1001, 4'b0111, 4'b0000, 1'b0, 4});
        vecs.push_back('{"MOD 15%14",    4'b1011, 4'b1111, 4'b1110, 4'b0001, 4'b0000, 1'b0, 4});
        vecs.push_back('{"DIV 14/3",     4'b1010, 4'b1110, 4'b0011, 4'b0100, 4'b0000, 1'b0, 4});
        vecs.push_back('{"DIV 3/7",      4'b1010, 4'b0011, 4'b0111, 4'b0000, 4'b0100, 1'b0, 4});
        vecs.push_back('{"illegal 1100", 4'b1100, 4'b0101, 4'b0011, 4'b0000, 4'b0100, 1'b0, 0});
        vecs.push_back('{"illegal 1111", 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 1'b0, 0});

        bus4.in_valid = 1'b0; bus4.A = '0; bus4.B = '0; bus4.ALUControl = '0; bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.ALUControl = '0; bus8.out_ready = 1'b1;
        rst4_n = 1'b0;
        rst8_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst4_n = 1'b1;
        rst8_n = 1'b1;
        @(posedge clk); #1;

        check("reset in_ready",    32'(bus4.in_ready),    32'd1);
        check("reset out_valid",   32'(bus4.out_valid),   32'd0);
        check("reset RESULT",      32'(bus4.RESULT),      32'd0);
        check("reset flags",       32'(bus4.flags),       32'd0);
        check("reset div_by_zero", 32'(bus4.div_by_zero), 32'd0);
        check("reset8 in_ready",   32'(bus8.in_ready),    32'd1);
        check("reset8 out_valid",  32'(bus8.out_valid),   32'd0);

        // Table: back-to-back issue with out_ready held high
        foreach (vecs[i]) begin
            issue4(vecs[i].op, vecs[i].a, vecs[i].b, edges);
            $display("txn %s: result=%b flags=%b dbz=%b edges=%0d",
                     vecs[i].name, bus4.RESULT, bus4.flags, bus4.div_by_zero, edges);
            check({vecs[i].name, " result"}, 32'(bus4.RESULT),      32'(vecs[i].res));
            check({vecs[i].name, " flags"},  32'(bus4.flags),       32'(vecs[i].flg));
            check({vecs[i].name, " dbz"},    32'(bus4.div_by_zero), 32'(vecs[i].dbz));
            check({vecs[i].name, " edges"},  32'(edges),            32'(vecs[i].edges));
        end
        @(posedge clk); #1;
        check("drain out_valid", 32'(bus4.out_valid), 32'd0);

        // N=8 backpressure: DIV 200/7 held in DONE while an ADD waits
        bus8.out_ready = 1'b0;
        issue8(4'b1010, 8'd200, 8'd7, edges);
        $display("txn DIV8 200/7: result=%0d flags=%b edges=%0d", bus8.RESULT, bus8.flags, edges);
        check("div8 edges",  32'(edges),       32'd8);
        check("div8 result", 32'(bus8.RESULT), 32'd28);
        check("div8 flags",  32'(bus8.flags),  32'd0);
        bus8.ALUControl = 4'b0000;
        bus8.A          = 8'd10;
        bus8.B          = 8'd20;
        bus8.in_valid   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall out_valid", 32'(bus8.out_valid), 32'd1);
            check("stall in_ready",  32'(bus8.in_ready),  32'd0);
            check("stall RESULT",    32'(bus8.RESULT),    32'd28);
            check("stall flags",     32'(bus8.flags),     32'd0);
        end
        bus8.out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(bus8.in_ready), 32'd1);
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        $display("txn ADD8 10+20 handoff: result=%0d flags=%b", bus8.RESULT, bus8.flags);
        check("handoff out_valid", 32'(bus8.out_valid), 32'd1);
        check("handoff RESULT",    32'(bus8.RESULT),    32'd30);
        check("handoff flags",     32'(bus8.flags),     32'd0);
        @(posedge clk); #1;
        check("handoff drained", 32'(bus8.out_valid), 32'd0);

        // N=8 reset three cycles into a divide
        bus8.ALUControl = 4'b1010;
        bus8.A          = 8'd250;
        bus8.B          = 8'd3;
        bus8.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid-div in_ready", 32'(bus8.in_ready), 32'd0);
        rst8_n = 1'b0;
        #1;
        check("async RESULT",    32'(bus8.RESULT),    32'd0);
        check("async out_valid", 32'(bus8.out_valid), 32'd0);
        check("async flags",     32'(bus8.flags),     32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst8_n = 1'b1;
        #1;
        check("post-reset in_ready", 32'(bus8.in_ready), 32'd1);
        seen_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus8.out_valid) seen_valid++;
        end
        check("aborted div never presented", 32'(seen_valid), 32'd0);
        issue8(4'b0000, 8'd3, 8'd4, edges);
        $display("txn ADD8 3+4: result=%0d flags=%b edges=%0d", bus8.RESULT, bus8.flags, edges);
        check("add after reset result", 32'(bus8.RESULT), 32'd7);
        check("add after reset flags",  32'(bus8.flags),  32'd0);
        check("add after reset edges",  32'(edges),       32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
